prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 118 +++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed big-endian word stream into program RAM, then hands the RAM back to the processor.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing 16-bit sum of the program words.
module prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH = 128,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] proc_pc,
  input  logic              proc_read_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [DATA_W-1:0] ram_din,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [3:0] IDLE = 4'd0, LEN_HI = 4'd1, LEN_LO = 4'd2, DAT_HI = 4'd3, DAT_LO = 4'd4;
  localparam logic [3:0] DONE = 4'd7, ERR = 4'd8;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [3:0] CS_HI = 4'd5, CS_LO = 4'd6, LAST = CS_HI;
`else
  localparam logic [3:0] LAST = DONE;
`endif
  logic [3:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   len_q, len_d, words_q, words_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, take;
  logic [15:0]       word;
  assign in_ready = state_q != IDLE && state_q != DONE && state_q != ERR;
  assign take = in_valid && in_ready;
  assign word = {hi_q, in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
  always_comb sum_d = load_req ? '0 : (take && state_q == DAT_LO) ? sum_q + word : sum_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
`endif
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    len_d = len_q;
    words_d = words_q;
    din_d = din_q;
    addr_d = addr_q;
    we_d = 1'b0;
    if (load_req) begin
      state_d = LEN_HI;
      words_d = '0;
    end else if (take) begin
      case (state_q)
        LEN_HI, DAT_HI: begin
          hi_d = in_data;
          state_d = state_q + 4'd1;
        end
        LEN_LO: begin
          len_d = word[ADDR_W:0];
          state_d = (word == 16'd0 || word > DEPTH_W) ? ERR : DAT_HI;
        end
        DAT_LO: begin
          din_d = DATA_W'(word);
          addr_d = words_q[ADDR_W-1:0];
          we_d = 1'b1;
          words_d = words_q + 1'b1;
          state_d = (words_d == len_q) ? LAST : DAT_HI;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CS_HI: begin
          hi_d = in_data;
          state_d = CS_LO;
        end
        CS_LO: state_d = (word == sum_q) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q <= '0;
      len_q <= '0;
      words_q <= '0;
      din_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      len_q <= len_d;
      words_q <= words_d;
      din_q <= din_d;
      addr_q <= addr_d;
      we_q <= we_d;
    end
  // the final write pulse keeps the loader on the RAM port and holds off done/start for one cycle
  assign busy = in_ready || we_q;
  assign done = state_q == DONE && !we_q;
  assign start = done;
  assign err = state_q == ERR;
  assign ram_addr = busy ? addr_q : proc_pc;
  assign ram_read_en = !busy && proc_read_en;
  assign ram_write_en = we_q;
  assign ram_din = din_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vector table plus hand-written restart, backpressure and async-reset sequences.
module tb_prog_loader;
  logic        clk = 1'b0, rst_n = 1'b0, load_req = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [6:0]  proc_pc = '0;
  logic        proc_read_en = 1'b0;
  logic        in_ready, ram_read_en, ram_write_en, start, busy, done, err;
  logic [6:0]  ram_addr;
  logic [15:0] ram_din;
  logic [7:0]  words_loaded;
  logic [15:0] mem [128];
  int          wcount = 0, checks = 0, failures = 0;

  typedef struct {
    logic [15:0] len;
    int          n;
    logic [15:0] w [4];
    logic        ok;
  } vec_t;
  vec_t v [6];

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .proc_pc(proc_pc), .proc_read_en(proc_read_en), .ram_addr(ram_addr),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .ram_din(ram_din), .start(start),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ram_write_en) begin
      mem[ram_addr] <= ram_din;
      wcount <= wcount + 1;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("send_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    send_byte(b);
  endtask

  task automatic send_word(input logic [15:0] w, input logic gaps);
    if (gaps) begin
      send_gap(w[15:8]);
      send_gap(w[7:0]);
    end else begin
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, ram_write_en, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_words"}, words_loaded, 0);
    chk({tag, "_din"}, ram_din, 0);
  endtask

  initial begin
    logic [15:0] sum;
    int wbase;
    v[0] = '{16'd3,      3, '{16'h1234, 16'hABCD, 16'h00FF, 16'h0000}, 1'b1};
    v[1] = '{16'h0000,   0, '{16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};
    v[2] = '{16'h0081,   0, '{16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};
    v[3] = '{16'h0103,   0, '{16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};
    v[4] = '{16'd1,      1, '{16'hBEEF, 16'h0, 16'h0, 16'h0}, 1'b1};
    v[5] = '{16'd4,      4, '{16'h0102, 16'hF00D, 16'h8000, 16'h7FFF}, 1'b1};

    #1;
    check_idle_outputs("reset");
    proc_pc = 7'h2A;
    proc_read_en = 1'b1;
    #1;
    chk("reset_addr_pass", ram_addr, 7'h2A);
    chk("reset_rd_pass", ram_read_en, 1);
    #21 rst_n = 1'b1;
    tick();

    // bytes offered while idle must not be consumed
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (4) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
    end
    chk("idle_words", words_loaded, 0);
    in_valid = 1'b0;

    // 4-word load with random gaps; processor reads must be blocked while busy
    pulse_load();
    chk("bp_busy", busy, 1);
    chk("bp_rd_blocked", ram_read_en, 0);
    send_word(16'd4, 1'b1);
    foreach (v[5].w[k]) send_word(v[5].w[k], 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(16'h0102 + 16'hF00D + 16'h8000 + 16'h7FFF, 1'b1);
`endif
    tick();
    chk("bp_done", done, 1);
    chk("bp_words", words_loaded, 4);
    for (int k = 0; k < 4; k++) chk("bp_ram", mem[k], v[5].w[k]);

    for (int i = 0; i < 6; i++) begin
      wbase = wcount;
      pulse_load();
      chk("vec_cleared", words_loaded, 0);
      send_word(v[i].len, 1'b0);
      sum = '0;
      for (int k = 0; k < v[i].n; k++) begin
        send_word(v[i].w[k], 1'b0);
        sum = sum + v[i].w[k];
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      if (v[i].ok) send_word(sum, 1'b0);
`endif
      tick();
      chk("vec_done", done, v[i].ok);
      chk("vec_err", err, !v[i].ok);
      chk("vec_start", start, v[i].ok);
      chk("vec_words", words_loaded, v[i].n);
      chk("vec_in_ready", in_ready, 0);
      chk("vec_busy", busy, 0);
      chk("vec_writes", wcount - wbase, v[i].n);
      for (int k = 0; k < v[i].n; k++) chk("vec_ram", mem[k], v[i].w[k]);
    end

    proc_pc = 7'h55;
    proc_read_en = 1'b1;
    #1;
    chk("pass_addr", ram_addr, 7'h55);
    chk("pass_rd", ram_read_en, 1);
    proc_read_en = 1'b0;
    #1;
    chk("pass_rd_off", ram_read_en, 0);

`ifndef PROG_LOADER_CHECKSUM_EN
    // done must wait for the final write pulse to finish
    pulse_load();
    send_word(16'd1, 1'b0);
    send_word(16'h5A5A, 1'b0);
    chk("last_we", ram_write_en, 1);
    chk("last_done_early", done, 0);
    chk("last_busy", busy, 1);
    chk("last_addr", ram_addr, 0);
    tick();
    chk("last_done", done, 1);
`endif

    // restart after word 1 of 4
    pulse_load();
    send_word(16'd4, 1'b0);
    send_word(16'hDEAD, 1'b0);
    pulse_load();
    chk("rs_busy", busy, 1);
    chk("rs_words", words_loaded, 0);
    chk("rs_done", done, 0);
    chk("rs_ram_old", mem[0], 16'hDEAD);
    wbase = wcount;
    send_word(16'd2, 1'b0);
    send_word(16'h1111, 1'b0);
    send_word(16'h2222, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(16'h3333, 1'b0);
`endif
    tick();
    chk("rs_done2", done, 1);
    chk("rs_words2", words_loaded, 2);
    chk("rs_writes", wcount - wbase, 2);
    chk("rs_ram0", mem[0], 16'h1111);
    chk("rs_ram1", mem[1], 16'h2222);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_load();
    send_word(16'd2, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    send_word(16'h0004, 1'b0);
    tick();
    chk("cs_err", err, 1);
    chk("cs_start", start, 0);
    chk("cs_done", done, 0);
`endif

    // async reset between hi and lo byte of a word
    pulse_load();
    send_word(16'd2, 1'b0);
    wbase = wcount;
    send_byte(8'h77);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("arst_mid");
    #5 rst_n = 1'b1;
    tick();
    chk("arst_mid_writes", wcount - wbase, 0);

    // async reset while a write pulse is in flight
    pulse_load();
    send_word(16'd2, 1'b0);
    wbase = wcount;
    send_word(16'hCAFE, 1'b0);
    chk("arst_we_before", ram_write_en, 1);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("arst_wr");
    tick();
    chk("arst_wr_dropped", wcount - wbase, 0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
